// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column FWFT FIFOs that de-skew MAC array psums into aligned rows.
// Define PSUM_OFIFO_OVF_EN to add a sticky o_overflow flag for dropped writes.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full
`ifdef PSUM_OFIFO_OVF_EN
    ,
    output logic                   o_overflow
`endif
);
    localparam int aw = $clog2(depth);
    // Every column pops together, so one read pointer serves all of them.
    logic [aw:0]    rd_ptr;
    logic [col-1:0] empty, full, push;
    logic           pop;
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign pop     = rd && o_valid;
    always_ff @(posedge clk) begin
        if (reset) rd_ptr <= '0;
        else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
    genvar j;
    generate
        for (j = 0; j < col; j++) begin : g_col
            logic [psum_bw-1:0] mem [depth];
            logic [aw:0]        wr_ptr;
            assign empty[j] = wr_ptr == rd_ptr;
            assign full[j]  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
            assign push[j]  = wr[j] && (!full[j] || pop);
            assign out[psum_bw*j +: psum_bw] = o_valid ? mem[rd_ptr[aw-1:0]] : '0;
            always_ff @(posedge clk) begin
                if (push[j]) mem[wr_ptr[aw-1:0]] <= in[psum_bw*j +: psum_bw];
            end
            always_ff @(posedge clk) begin
                if (reset) wr_ptr <= '0;
                else if (push[j]) wr_ptr <= wr_ptr + 1'b1;
            end
        end
    endgenerate
`ifdef PSUM_OFIFO_OVF_EN
    always_ff @(posedge clk) begin
        if (reset) o_overflow <= 1'b0;
        else if ((|(wr & full)) && !pop) o_overflow <= 1'b1;
    end
`endif
endmodule
